// File: rtl/controle_vedacao.sv
// Cork-press sealing controller: times the press stroke, counts corks in the
// magazine and raises low-stock / empty alarms for the line controller.
module controle_vedacao #(
  parameter int unsigned ROLHAS_MAX   = 12,
  parameter int unsigned LIMIAR_BAIXO = 3,
  parameter int unsigned T_PRESS      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pos_ve,
  input  logic       abastecer,
  output logic       atuador,
  output logic       ve_done,
  output logic       alarme,
  output logic       baixo_estoque,
  output logic [3:0] rolhas
);

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] CNT_MAX = CW'(ROLHAS_MAX);
  localparam logic [CW-1:0] CNT_LOW = CW'(LIMIAR_BAIXO);
  localparam logic [CW-1:0] TMR_END = CW'(T_PRESS - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRESS,
    DONE,
    WAIT_REL,
    FALTA
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   timer, timer_nxt;
  logic [CW-1:0]   rolhas_nxt;
  logic            consome;

  // Next state, press timer and magazine count
  always_comb begin
    state_nxt  = state;
    timer_nxt  = timer;
    rolhas_nxt = rolhas;
    consome    = 1'b0;

    case (state)
      IDLE: begin
        if (pos_ve) begin
          if (rolhas != '0) begin
            state_nxt = PRESS;
            timer_nxt = '0;
          end else begin
            state_nxt = FALTA;
          end
        end
      end
      PRESS: begin
        if (!pos_ve) begin
          state_nxt = IDLE;
        end else if (timer == TMR_END) begin
          state_nxt = DONE;
          consome   = 1'b1;
        end else begin
          timer_nxt = timer + CW'(1);
        end
      end
      DONE:     state_nxt = WAIT_REL;
      WAIT_REL: if (!pos_ve) state_nxt = IDLE;
      FALTA:    if (abastecer) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase

    // A refill always overrides a simultaneous cork consumption
    if (abastecer) begin
      rolhas_nxt = CNT_MAX;
    end else if (consome && (rolhas != '0)) begin
      rolhas_nxt = rolhas - CW'(1);
    end
  end

  // State, counters and outputs registered from the next-state values
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      timer         <= '0;
      rolhas        <= CNT_MAX;
      atuador       <= 1'b0;
      ve_done       <= 1'b0;
      alarme        <= 1'b0;
      baixo_estoque <= 1'b0;
    end else begin
      state         <= state_nxt;
      timer         <= timer_nxt;
      rolhas        <= rolhas_nxt;
      atuador       <= (state_nxt == PRESS);
      ve_done       <= (state_nxt == DONE);
      alarme        <= (rolhas_nxt == '0);
      baixo_estoque <= (rolhas_nxt != '0) && (rolhas_nxt <= CNT_LOW);
    end
  end

endmodule

// File: tb/tb_controle_vedacao.sv
// Randomised and directed bench for controle_vedacao against a stroke-level
// reference model of the sealing station.
module tb_controle_vedacao;

  localparam int unsigned MAXC = 12;
  localparam int unsigned LIM  = 3;
  localparam int unsigned TP   = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pos_ve = 1'b0;
  logic       abastecer = 1'b0;
  logic       atuador, ve_done, alarme, baixo_estoque;
  logic [3:0] rolhas;

  int errors = 0;
  int checks = 0;

  // Reference model: remaining stroke cycles, pulse/hold/starved flags, stock
  int m_press_left;
  int m_stock;
  bit m_done, m_hold, m_starved;

  controle_vedacao #(.ROLHAS_MAX(MAXC), .LIMIAR_BAIXO(LIM), .T_PRESS(TP)) dut (
    .clk(clk), .reset(reset), .pos_ve(pos_ve), .abastecer(abastecer),
    .atuador(atuador), .ve_done(ve_done), .alarme(alarme),
    .baixo_estoque(baixo_estoque), .rolhas(rolhas)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_press_left = 0;
    m_stock      = MAXC;
    m_done       = 1'b0;
    m_hold       = 1'b0;
    m_starved    = 1'b0;
  endfunction

  function automatic void model_step(input bit pv, input bit ab);
    bit used = 1'b0;
    if (m_starved) begin
      if (ab) m_starved = 1'b0;
    end else if (m_done) begin
      m_done = 1'b0;
      m_hold = 1'b1;
    end else if (m_hold) begin
      if (!pv) m_hold = 1'b0;
    end else if (m_press_left > 0) begin
      if (!pv) m_press_left = 0;
      else if (m_press_left == 1) begin
        m_press_left = 0;
        m_done = 1'b1;
        used = 1'b1;
      end else m_press_left--;
    end else if (pv) begin
      if (m_stock > 0) m_press_left = TP;
      else m_starved = 1'b1;
    end
    if (ab) m_stock = MAXC;
    else if (used) m_stock--;
  endfunction

  function automatic logic [7:0] exp_v();
    return {m_press_left > 0, m_done, m_stock == 0,
            (m_stock > 0) && (m_stock <= int'(LIM)), 4'(m_stock)};
  endfunction

  function automatic logic [7:0] obs_v();
    return {atuador, ve_done, alarme, baixo_estoque, rolhas};
  endfunction

  // One clock: drive inputs, advance model on the edge, settle
  task automatic cycle(input bit pv, input bit ab);
    pos_ve = pv;
    abastecer = ab;
    @(posedge clk);
    if (reset) model_step(pv, ab);
    #2;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs_v() !== exp_v()) begin
      errors++;
      $display("FAIL reset_async: got %b want %b", obs_v(), exp_v());
    end
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b0);
      checks++;
      if (obs_v() !== exp_v()) begin
        errors++;
        $display("FAIL reset_hold k=%0d: got %b want %b", k, obs_v(), exp_v());
      end
    end
    #1 reset = 1'b1;
    cycle(1'b0, 1'b0);
    checks++;
    if (obs_v() !== exp_v()) begin
      errors++;
      $display("FAIL reset_release: got %b want %b", obs_v(), exp_v());
    end
  endtask

  task automatic test_seal_basic();
    int atu = 0, dn = 0;
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, 1'b0);
      atu += int'(atuador);
      dn  += int'(ve_done);
      checks++;
      if (obs_v() !== exp_v()) begin
        errors++;
        $display("FAIL seal_basic k=%0d: got %b want %b", k, obs_v(), exp_v());
      end
    end
    checks++;
    if (atu != 4 || dn != 1 || rolhas !== 4'd11) begin
      errors++;
      $display("FAIL seal_basic_totals: got atu=%0d done=%0d rolhas=%0d want 4 1 11",
               atu, dn, rolhas);
    end
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
  endtask

  task automatic test_drain();
    for (int s = 0; s < 11; s++) begin
      for (int k = 0; k < 8; k++) begin
        cycle(k < 6, 1'b0);
        checks++;
        if (obs_v() !== exp_v()) begin
          errors++;
          $display("FAIL drain s=%0d k=%0d: got %b want %b", s, k, obs_v(), exp_v());
        end
      end
    end
    checks++;
    if (rolhas !== 4'd0 || alarme !== 1'b1 || baixo_estoque !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty: got rolhas=%0d alarme=%b baixo=%b want 0 1 0",
               rolhas, alarme, baixo_estoque);
    end
  endtask

  task automatic test_falta();
    int atu = 0, dn = 0;
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, 1'b0);
      atu += int'(atuador);
      checks++;
      if (obs_v() !== exp_v()) begin
        errors++;
        $display("FAIL falta_wait k=%0d: got %b want %b", k, obs_v(), exp_v());
      end
    end
    cycle(1'b1, 1'b1);
    checks++;
    if (atu != 0 || rolhas !== 4'd12 || alarme !== 1'b0 || atuador !== 1'b0) begin
      errors++;
      $display("FAIL falta_refill: got atu=%0d rolhas=%0d alarme=%b want 0 12 0",
               atu, rolhas, alarme);
    end
    for (int k = 0; k < 8; k++) begin
      cycle(k < 6, 1'b0);
      dn += int'(ve_done);
      checks++;
      if (obs_v() !== exp_v()) begin
        errors++;
        $display("FAIL falta_seal k=%0d: got %b want %b", k, obs_v(), exp_v());
      end
    end
    checks++;
    if (dn != 1 || rolhas !== 4'd11) begin
      errors++;
      $display("FAIL falta_seal_totals: got done=%0d rolhas=%0d want 1 11", dn, rolhas);
    end
  endtask

  task automatic test_abort();
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    checks++;
    if (atuador !== 1'b0 || ve_done !== 1'b0 || rolhas !== 4'd11) begin
      errors++;
      $display("FAIL abort: got atu=%b done=%b rolhas=%0d want 0 0 11",
               atuador, ve_done, rolhas);
    end
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 1'b0);
      checks++;
      if (obs_v() !== exp_v()) begin
        errors++;
        $display("FAIL abort_after k=%0d: got %b want %b", k, obs_v(), exp_v());
      end
    end
  endtask

  task automatic test_refill_on_dec();
    bit seen_done = 1'b0;
    for (int s = 0; s < 6; s++)
      for (int k = 0; k < 8; k++) cycle(k < 6, 1'b0);
    checks++;
    if (rolhas !== 4'd5) begin
      errors++;
      $display("FAIL refill_setup: got rolhas=%0d want 5", rolhas);
    end
    for (int k = 0; k < 8; k++) begin
      cycle(k < 6, k == 4);
      if (k == 4) begin
        seen_done = ve_done;
        checks++;
        if (rolhas !== 4'd12 || ve_done !== 1'b1) begin
          errors++;
          $display("FAIL refill_on_dec: got rolhas=%0d done=%b want 12 1", rolhas, ve_done);
        end
      end
      checks++;
      if (obs_v() !== exp_v()) begin
        errors++;
        $display("FAIL refill_seq k=%0d: got %b want %b", k, obs_v(), exp_v());
      end
    end
    if (!seen_done) $display("note: done pulse not seen on refill edge");
  endtask

  task automatic test_async_mid_press();
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    #1 reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (atuador !== 1'b0 || ve_done !== 1'b0 || rolhas !== 4'd12) begin
      errors++;
      $display("FAIL async_mid_press: got atu=%b done=%b rolhas=%0d want 0 0 12",
               atuador, ve_done, rolhas);
    end
    for (int k = 0; k < 2; k++) cycle(1'b1, 1'b0);
    #1 reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cycle(1'b0, 1'b0);
      checks++;
      if (obs_v() !== exp_v()) begin
        errors++;
        $display("FAIL async_after k=%0d: got %b want %b", k, obs_v(), exp_v());
      end
    end
  endtask

  task automatic test_random();
    bit pv = 1'b0;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 3) == 0) pv = ~pv;
      cycle(pv, $urandom_range(0, 39) == 0);
      checks++;
      if (obs_v() !== exp_v()) begin
        errors++;
        $display("FAIL random k=%0d: got %b want %b", k, obs_v(), exp_v());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_seal_basic();
    test_drain();
    test_falta();
    test_abort();
    test_refill_on_dec();
    test_async_mid_press();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/controle_vedacao.md
CONTROLE_VEDACAO -- requirements
Module: controle_vedacao

Interface
REQ-001 The block SHALL have parameter ROLHAS_MAX, default 12: cork magazine capacity, range 1..15.
REQ-002 The block SHALL have parameter LIMIAR_BAIXO, default 3: low-stock threshold, less than ROLHAS_MAX.
REQ-003 The block SHALL have parameter T_PRESS, default 4: press duration in clock cycles, range 1..15.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 pos_ve  input  1  level: bottle held in sealing position by the line controller.
REQ-007 abastecer  input  1  one-cycle refill pulse from the operator: magazine reloaded to full.
REQ-008 atuador  output  1  press actuator drive.
REQ-009 ve_done  output  1  one-cycle pulse: seal complete.
REQ-010 alarme  output  1  magazine empty; feeds the line controller's motor inhibit.
REQ-011 baixo_estoque  output  1  stock at or below LIMIAR_BAIXO but not empty.
REQ-012 rolhas  output  4  current cork count.

Function
REQ-013 The FSM SHALL have states IDLE, PRESS, DONE, WAIT_REL and FALTA.
REQ-014 All outputs SHALL be decoded from registered state and counters only (Moore), with no input-to-output combinational path.
REQ-015 In IDLE: pos_ve=1 and rolhas>0 -> PRESS with timer cleared; pos_ve=1 and rolhas=0 -> FALTA; otherwise stay in IDLE.
REQ-016 In PRESS: atuador SHALL be 1 and timer SHALL increment each cycle.
REQ-017 In PRESS: when timer=T_PRESS-1 and pos_ve=1, the FSM SHALL go to DONE and rolhas SHALL decrement by 1 on the same edge.
REQ-018 atuador SHALL be high for exactly T_PRESS consecutive cycles per completed seal.
REQ-019 In PRESS: pos_ve=0 on any cycle SHALL abort the seal -> IDLE, with no decrement and no ve_done; atuador SHALL be 0 from the next cycle.
REQ-020 In DONE: ve_done SHALL be 1 for exactly one cycle, then the FSM SHALL go unconditionally to WAIT_REL.
REQ-021 In WAIT_REL: the FSM SHALL stay until pos_ve=0, then go to IDLE, so no second seal occurs on the same bottle.
REQ-022 In FALTA: atuador SHALL be 0, and the FSM SHALL go to IDLE on the edge where abastecer=1.
REQ-023 abastecer=1 in any state SHALL load rolhas to ROLHAS_MAX without changing the FSM state, except the FALTA->IDLE exit in REQ-022.
REQ-024 When abastecer=1 coincides with the decrement edge, the refill SHALL win: rolhas=ROLHAS_MAX, not ROLHAS_MAX-1.
REQ-025 rolhas SHALL never wrap below 0; no decrement SHALL occur at 0, guaranteed by REQ-015.
REQ-026 alarme SHALL equal (rolhas==0) in every state.
REQ-027 baixo_estoque SHALL equal (rolhas<=LIMIAR_BAIXO) and (rolhas!=0).
REQ-028 Latency: with pos_ve sampled 1 at edge E0 in IDLE, atuador SHALL be high for cycles E0..E0+T_PRESS-1, and ve_done SHALL be high in cycle E0+T_PRESS.

Reset
REQ-029 reset=0 SHALL immediately, without waiting for a clock edge, force state IDLE, timer 0 and rolhas=ROLHAS_MAX.
REQ-030 While reset=0, outputs SHALL be atuador=0, ve_done=0, alarme=0 and baixo_estoque=0.
REQ-031 Reset asserted mid-PRESS SHALL abort the seal with no ve_done and no decrement.
REQ-032 Release of reset SHALL be sampled synchronously; the first active edge evaluates IDLE.

Verification
REQ-033 Defaults, reset then pos_ve held high -> atuador high exactly 4 cycles, then ve_done one pulse, rolhas 12->11, FSM in WAIT_REL until pos_ve=0.
REQ-034 Twelve complete seal cycles -> rolhas 0 and alarme=1; baixo_estoque=1 only while rolhas is 3, 2 or 1.
REQ-035 rolhas=0 and pos_ve=1 -> FALTA with atuador never high; abastecer pulse -> rolhas=12, alarme=0, then the seal completes normally.
REQ-036 pos_ve dropped in the 2nd PRESS cycle -> IDLE, atuador 0 next cycle, no ve_done, rolhas unchanged.
REQ-037 rolhas=5 and abastecer on the decrement edge -> rolhas=12 and ve_done still pulses.
REQ-038 reset=0 asynchronously mid-PRESS -> atuador 0 before the next edge, rolhas=12, no ve_done.
